pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 117 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stalls on load-use, flushes on taken branches and
// freezes the whole pipeline while a data-memory access is outstanding.
module pipe_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_RegDst,
    input  logic        ex_RegWEn,
    input  logic [1:0]  ex_WBSel,
    input  logic        ex_br_taken,
    input  logic        mem_MemRW,
    input  logic        mem_RegWEn,
    input  logic [1:0]  mem_WBSel,
    input  logic        dmem_ready,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        mem_wb_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        dmem_req,
    output logic        dmem_err,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN_S,
        WAIT_S,
        ERR_S
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_nxt;
    logic       mem_access;
    logic       load_use;

    assign mem_access = mem_MemRW | (mem_RegWEn & (mem_WBSel == 2'b00));
    assign load_use   = ex_RegWEn & (ex_WBSel == 2'b00) & (ex_RegDst != 5'd0) &
                        ((id_use_rs1 & (id_rs1 == ex_RegDst)) |
                         (id_use_rs2 & (id_rs2 == ex_RegDst)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN_S;
            wait_cnt  <= 8'd0;
            stall_cnt <= 16'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (!pc_en && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

    // Reset forces a bubble into both front-end registers regardless of state.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = 8'd0;
        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        dmem_req     = 1'b0;
        dmem_err     = (state == ERR_S);

        if (!rst_n) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            case (state)
                RUN_S: begin
                    if (mem_access) begin
                        dmem_req  = 1'b1;
                        state_nxt = WAIT_S;
                    end else if (ex_br_taken) begin
                        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (load_use) begin
                        ex_mem_en   = 1'b1;
                        mem_wb_en   = 1'b1;
                        id_ex_flush = 1'b1;
                    end else begin
                        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
                    end
                end
                // A ready pulse on the last allowed cycle still completes the access.
                WAIT_S: begin
                    if (dmem_ready) begin
                        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
                        state_nxt = RUN_S;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state_nxt = ERR_S;
                    end else begin
                        wait_cnt_nxt = wait_cnt + 8'd1;
                    end
                end
                ERR_S: begin
                    state_nxt = ERR_S;
                end
                default: begin
                    state_nxt = RUN_S;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl (TIMEOUT=4).
module tb_pipe_hazard_ctrl;

    localparam logic [4:0] EN_ALL  = 5'b11111;
    localparam logic [4:0] EN_NONE = 5'b00000;
    localparam logic [4:0] EN_LU   = 5'b00011;
    localparam logic [1:0] FL_NONE = 2'b00;
    localparam logic [1:0] FL_BOTH = 2'b11;
    localparam logic [1:0] FL_IDEX = 2'b01;

    typedef struct packed {
        logic [4:0]  en;
        logic [1:0]  fl;
        logic        req;
        logic        err;
        logic [15:0] stall;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs1, id_rs2, ex_RegDst;
    logic        id_use_rs1, id_use_rs2, ex_RegWEn, ex_br_taken;
    logic [1:0]  ex_WBSel, mem_WBSel;
    logic        mem_MemRW, mem_RegWEn, dmem_ready;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, dmem_req, dmem_err;
    logic [15:0] stall_cnt;

    exp_t        sb_q[$];
    logic [15:0] model_stall;
    int          checks = 0;
    int          passed = 0;

    pipe_hazard_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_RegDst(ex_RegDst), .ex_RegWEn(ex_RegWEn), .ex_WBSel(ex_WBSel),
        .ex_br_taken(ex_br_taken),
        .mem_MemRW(mem_MemRW), .mem_RegWEn(mem_RegWEn), .mem_WBSel(mem_WBSel),
        .dmem_ready(dmem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .dmem_req(dmem_req), .dmem_err(dmem_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag);
        exp_t e;
        logic [4:0] en_obs;
        logic [1:0] fl_obs;
        e = sb_q.pop_front();
        en_obs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
        fl_obs = {if_id_flush, id_ex_flush};
        checks++;
        assert (en_obs === e.en) passed++;
        else begin
            $display("[TB] FAIL %s.enables got %b want %b", tag, en_obs, e.en);
            $error("[TB] %s.enables", tag);
        end
        checks++;
        assert (fl_obs === e.fl) passed++;
        else begin
            $display("[TB] FAIL %s.flushes got %b want %b", tag, fl_obs, e.fl);
            $error("[TB] %s.flushes", tag);
        end
        checks++;
        assert (dmem_req === e.req) passed++;
        else begin
            $display("[TB] FAIL %s.dmem_req got %b want %b", tag, dmem_req, e.req);
            $error("[TB] %s.dmem_req", tag);
        end
        checks++;
        assert (stall_cnt === e.stall) passed++;
        else begin
            $display("[TB] FAIL %s.stall_cnt got %0d want %0d", tag, stall_cnt, e.stall);
            $error("[TB] %s.stall_cnt", tag);
        end
        if (rst_n) begin
            checks++;
            assert (dmem_err === e.err) passed++;
            else begin
                $display("[TB] FAIL %s.dmem_err got %b want %b", tag, dmem_err, e.err);
                $error("[TB] %s.dmem_err", tag);
            end
        end
    endtask

    // One cycle: queue the expectation, check mid-cycle, then advance the stall model.
    task automatic applyStimulus(input logic [4:0] en, input logic [1:0] fl,
                                 input logic req, input logic err, input string tag);
        exp_t e;
        e.en = en; e.fl = fl; e.req = req; e.err = err; e.stall = model_stall;
        sb_q.push_back(e);
        @(negedge clk);
        checkOutput(tag);
        if (!rst_n)
            model_stall = 16'd0;
        else if (!en[4] && model_stall != 16'hFFFF)
            model_stall = model_stall + 16'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_RegDst = 5'd0; ex_RegWEn = 1'b0; ex_WBSel = 2'b01; ex_br_taken = 1'b0;
        mem_MemRW = 1'b0; mem_RegWEn = 1'b0; mem_WBSel = 2'b01; dmem_ready = 1'b0;
    endtask

    initial begin
        clearInputs();
        rst_n = 1'b0;
        model_stall = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(EN_NONE, FL_BOTH, 1'b0, 1'b0, "reset");
        rst_n = 1'b1;
        applyStimulus(EN_ALL, FL_NONE, 1'b0, 1'b0, "idle");

        // Load-use hazards on rs1, then rs2, and the non-hazard variants
        ex_RegDst = 5'd5; ex_RegWEn = 1'b1; ex_WBSel = 2'b00; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        applyStimulus(EN_LU, FL_IDEX, 1'b0, 1'b0, "lu_rs1");
        ex_RegWEn = 1'b0;
        applyStimulus(EN_ALL, FL_NONE, 1'b0, 1'b0, "lu_after");
        ex_RegWEn = 1'b1; ex_RegDst = 5'd0; id_rs1 = 5'd0;
        applyStimulus(EN_ALL, FL_NONE, 1'b0, 1'b0, "lu_x0");
        ex_RegDst = 5'd7; id_use_rs1 = 1'b0; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        applyStimulus(EN_LU, FL_IDEX, 1'b0, 1'b0, "lu_rs2");
        id_use_rs2 = 1'b0;
        applyStimulus(EN_ALL, FL_NONE, 1'b0, 1'b0, "lu_unused");
        id_use_rs2 = 1'b1; ex_WBSel = 2'b01;
        applyStimulus(EN_ALL, FL_NONE, 1'b0, 1'b0, "lu_alu");
        ex_WBSel = 2'b00; ex_br_taken = 1'b1;
        applyStimulus(EN_ALL, FL_BOTH, 1'b0, 1'b0, "br_over_lu");
        clearInputs();

        // Store with ready three cycles after the request
        mem_MemRW = 1'b1;
        applyStimulus(EN_NONE, FL_NONE, 1'b1, 1'b0, "mem_req");
        applyStimulus(EN_NONE, FL_NONE, 1'b0, 1'b0, "mem_wait0");
        applyStimulus(EN_NONE, FL_NONE, 1'b0, 1'b0, "mem_wait1");
        dmem_ready = 1'b1;
        applyStimulus(EN_ALL, FL_NONE, 1'b0, 1'b0, "mem_ready");
        mem_MemRW = 1'b0;
        applyStimulus(EN_ALL, FL_NONE, 1'b0, 1'b0, "ready_in_run");
        dmem_ready = 1'b0;

        // Load beats a taken branch; minimum two-cycle access; branch waits for RUN
        mem_RegWEn = 1'b1; mem_WBSel = 2'b00; ex_br_taken = 1'b1;
        applyStimulus(EN_NONE, FL_NONE, 1'b1, 1'b0, "ld_over_br");
        dmem_ready = 1'b1;
        applyStimulus(EN_ALL, FL_NONE, 1'b0, 1'b0, "ld_min_ready");
        mem_RegWEn = 1'b0; dmem_ready = 1'b0;
        applyStimulus(EN_ALL, FL_BOTH, 1'b0, 1'b0, "br_after_ld");
        clearInputs();

        // Ready on the final allowed wait cycle wins over the timeout
        mem_MemRW = 1'b1;
        applyStimulus(EN_NONE, FL_NONE, 1'b1, 1'b0, "tlast_req");
        for (int i = 0; i < 3; i++)
            applyStimulus(EN_NONE, FL_NONE, 1'b0, 1'b0, "tlast_wait");
        dmem_ready = 1'b1;
        applyStimulus(EN_ALL, FL_NONE, 1'b0, 1'b0, "tlast_ready");
        mem_MemRW = 1'b0; dmem_ready = 1'b0;
        applyStimulus(EN_ALL, FL_NONE, 1'b0, 1'b0, "tlast_run");

        // Timeout into ERR; ready and mem_access are ignored there
        mem_MemRW = 1'b1;
        applyStimulus(EN_NONE, FL_NONE, 1'b1, 1'b0, "tout_req");
        for (int i = 0; i < 4; i++)
            applyStimulus(EN_NONE, FL_NONE, 1'b0, 1'b0, "tout_wait");
        applyStimulus(EN_NONE, FL_NONE, 1'b0, 1'b1, "err_enter");
        dmem_ready = 1'b1;
        applyStimulus(EN_NONE, FL_NONE, 1'b0, 1'b1, "err_sticky");
        dmem_ready = 1'b0;
        rst_n = 1'b0;
        applyStimulus(EN_NONE, FL_BOTH, 1'b0, 1'b0, "err_reset");
        rst_n = 1'b1; mem_MemRW = 1'b0;
        applyStimulus(EN_ALL, FL_NONE, 1'b0, 1'b0, "after_err_reset");

        // Reset in the middle of WAIT abandons the access
        mem_MemRW = 1'b1;
        applyStimulus(EN_NONE, FL_NONE, 1'b1, 1'b0, "rw_req");
        applyStimulus(EN_NONE, FL_NONE, 1'b0, 1'b0, "rw_wait");
        rst_n = 1'b0;
        applyStimulus(EN_NONE, FL_BOTH, 1'b0, 1'b0, "rw_reset");
        rst_n = 1'b1; mem_MemRW = 1'b0;
        applyStimulus(EN_ALL, FL_NONE, 1'b0, 1'b0, "rw_run");
        mem_MemRW = 1'b1;
        applyStimulus(EN_NONE, FL_NONE, 1'b1, 1'b0, "rw_reissue");
        dmem_ready = 1'b1;
        applyStimulus(EN_ALL, FL_NONE, 1'b0, 1'b0, "rw_done");
        dmem_ready = 1'b0;

        // Long freeze in ERR saturates the stall counter
        applyStimulus(EN_NONE, FL_NONE, 1'b1, 1'b0, "sat_req");
        for (int i = 0; i < 4; i++)
            applyStimulus(EN_NONE, FL_NONE, 1'b0, 1'b0, "sat_wait");
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
            if (model_stall != 16'hFFFF)
                model_stall = model_stall + 16'd1;
        end
        #1;
        applyStimulus(EN_NONE, FL_NONE, 1'b0, 1'b1, "sat_hold");
        applyStimulus(EN_NONE, FL_NONE, 1'b0, 1'b1, "sat_hold2");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
